frame_dispatcher: RTL

//  Sequences the frame header decoder and routes each frame's payload to one of
//  NUM_HANDLERS consumers, selected by the 8-bit endpoint ID (EID).

---
 rtl/frame_pkg.sv | 19 +
 rtl/frame_eid_match.sv | 31 +++
 rtl/frame_dispatcher.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// Shared types and constants for the frame dispatcher: EID width, length-byte
// markers and the dispatcher FSM state encoding.
package frame_pkg;

    localparam int EID_W = 8;

    localparam logic [EID_W-1:0] EID_EMPTY = 8'h00;
    localparam logic [EID_W-1:0] EID_FRAG  = 8'hFF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACK    = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        END    = 3'd4,
        WAIT   = 3'd5
    } state_t;

endpackage

// File: rtl/frame_eid_match.sv
// Combinational priority match of a decoded EID against the per-handler
// configuration; the lowest enabled handler with an equal EID wins.
module frame_eid_match
    import frame_pkg::*;
#(
    parameter int NUM_HANDLERS = 4,
    parameter int SEL_W        = 2
) (
    input  logic [NUM_HANDLERS*EID_W-1:0] cfg_eid,
    input  logic [NUM_HANDLERS-1:0]       cfg_en,
    input  logic [EID_W-1:0]              eid,
    output logic [SEL_W-1:0]              sel,
    output logic                          hit
);

    // Scan from the top down so a lower index overrides any higher match
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = NUM_HANDLERS - 1; i >= 0; i--) begin
            if (cfg_en[i] && (cfg_eid[i*EID_W +: EID_W] == eid)) begin
                sel = SEL_W'(i);
                hit = 1'b1;
            end else begin
                sel = sel;
                hit = hit;
            end
        end
    end

endmodule

// File: rtl/frame_dispatcher.sv
// Sequences the header decoder and routes each frame payload to one of
// NUM_HANDLERS consumers, tracking fragment chains and stall aborts per handler.
module frame_dispatcher
    import frame_pkg::*;
#(
    parameter int NUM_HANDLERS = 4,
    parameter int STALL_LIMIT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_frame_valid,
    input  logic [7:0]                    in_frame_data,
    input  logic                          in_frame_data_valid,
    input  logic [EID_W-1:0]              header_eid,
    input  logic                          header_done,
    input  logic                          packet_is_empty,
    input  logic                          is_fragment,
    output logic                          header_done_clear,
    output logic                          frame_data_latch,
    input  logic [NUM_HANDLERS*EID_W-1:0] cfg_eid,
    input  logic [NUM_HANDLERS-1:0]       cfg_en,
    output logic [7:0]                    h_data,
    output logic [NUM_HANDLERS-1:0]       h_valid,
    input  logic [NUM_HANDLERS-1:0]       h_ready,
    output logic [NUM_HANDLERS-1:0]       h_sof,
    output logic [NUM_HANDLERS-1:0]       h_end,
    output logic                          h_end_frag,
    output logic [NUM_HANDLERS-1:0]       h_abort,
    output logic [CNT_W-1:0]              drop_count,
    output logic [CNT_W-1:0]              abort_count
);

    localparam int SEL_W   = (NUM_HANDLERS > 1) ? $clog2(NUM_HANDLERS) : 1;
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    state_t                  state_r, state_s;
    logic [SEL_W-1:0]        match_sel_s, sel_r;
    logic                    match_hit_s, hit_r, empty_r, frag_r;
    logic [NUM_HANDLERS-1:0] frag_open_r;
    logic                    first_sent_r;
    logic [STALL_W-1:0]      stall_cnt_r;
    logic [CNT_W-1:0]        drop_count_r, abort_count_r;
    logic                    clear_s, end_s, abort_s, drop_inc_s, stalled_s, accept_s;
    logic                    header_done_clear_r, h_end_frag_r;
    logic [NUM_HANDLERS-1:0] h_end_r, h_abort_r;

    frame_eid_match #(
        .NUM_HANDLERS (NUM_HANDLERS),
        .SEL_W        (SEL_W)
    ) u_match (
        .cfg_eid (cfg_eid),
        .cfg_en  (cfg_en),
        .eid     (header_eid),
        .sel     (match_sel_s),
        .hit     (match_hit_s)
    );

    // Next-state and payload-phase outputs; data path is a zero-latency pass-through
    always_comb begin
        state_s          = state_r;
        h_data           = 8'h00;
        h_valid          = '0;
        h_sof            = '0;
        frame_data_latch = 1'b0;
        clear_s          = 1'b0;
        end_s            = 1'b0;
        abort_s          = 1'b0;
        drop_inc_s       = 1'b0;
        stalled_s        = 1'b0;
        accept_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (header_done) begin
                    state_s = ACK;
                end else begin
                    state_s = IDLE;
                end
            end
            ACK: begin
                clear_s = 1'b1;
                if (!in_frame_valid) begin
                    state_s = END;
                end else if (empty_r) begin
                    state_s = WAIT;
                end else if (!hit_r) begin
                    state_s    = DRAIN;
                    drop_inc_s = 1'b1;
                end else begin
                    state_s = STREAM;
                end
            end
            STREAM: begin
                h_data           = in_frame_data;
                h_valid[sel_r]   = in_frame_data_valid;
                h_sof[sel_r]     = in_frame_data_valid & ~frag_open_r[sel_r] & ~first_sent_r;
                accept_s         = in_frame_data_valid & h_ready[sel_r];
                stalled_s        = in_frame_data_valid & ~h_ready[sel_r];
                frame_data_latch = accept_s;
                if (stall_cnt_r == STALL_W'(STALL_LIMIT)) begin
                    abort_s = 1'b1;
                    state_s = DRAIN;
                end else if (!in_frame_valid) begin
                    state_s = END;
                end else begin
                    state_s = STREAM;
                end
            end
            DRAIN: begin
                frame_data_latch = in_frame_data_valid;
                if (!in_frame_valid) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            END: begin
                // Empty and unmatched frames can land here when the frame ends during ACK
                end_s   = hit_r & ~empty_r;
                state_s = IDLE;
            end
            WAIT: begin
                if (!in_frame_valid) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state, per-frame header context, chain tracking and stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            sel_r        <= '0;
            hit_r        <= 1'b0;
            empty_r      <= 1'b0;
            frag_r       <= 1'b0;
            frag_open_r  <= '0;
            first_sent_r <= 1'b0;
            stall_cnt_r  <= '0;
        end else begin
            state_r <= state_s;
            if ((state_r == IDLE) && header_done) begin
                sel_r   <= match_sel_s;
                hit_r   <= match_hit_s;
                empty_r <= packet_is_empty;
                frag_r  <= is_fragment;
            end
            if (state_r == ACK) begin
                first_sent_r <= 1'b0;
            end else if (accept_s) begin
                first_sent_r <= 1'b1;
            end
            if (stalled_s && !abort_s) begin
                stall_cnt_r <= stall_cnt_r + STALL_W'(1);
            end else begin
                stall_cnt_r <= '0;
            end
            if (abort_s) begin
                frag_open_r[sel_r] <= 1'b0;
            end else if (end_s) begin
                frag_open_r[sel_r] <= frag_r;
            end
        end
    end

    // Registered pulse outputs and saturating statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            header_done_clear_r <= 1'b0;
            h_end_r             <= '0;
            h_end_frag_r        <= 1'b0;
            h_abort_r           <= '0;
            drop_count_r        <= '0;
            abort_count_r       <= '0;
        end else begin
            header_done_clear_r <= clear_s;
            h_end_r             <= '0;
            h_abort_r           <= '0;
            h_end_frag_r        <= end_s & frag_r;
            if (end_s) begin
                h_end_r[sel_r] <= 1'b1;
            end
            if (abort_s) begin
                h_abort_r[sel_r] <= 1'b1;
            end
            if (drop_inc_s && (drop_count_r != {CNT_W{1'b1}})) begin
                drop_count_r <= drop_count_r + CNT_W'(1);
            end
            if (abort_s && (abort_count_r != {CNT_W{1'b1}})) begin
                abort_count_r <= abort_count_r + CNT_W'(1);
            end
        end
    end

    assign header_done_clear = header_done_clear_r;
    assign h_end             = h_end_r;
    assign h_end_frag        = h_end_frag_r;
    assign h_abort           = h_abort_r;
    assign drop_count        = drop_count_r;
    assign abort_count       = abort_count_r;

endmodule
